// File: rtl/operand_fetch_seq.sv
// Two-operand fetch sequencer: reads operand A then operand B from a memory with
// one cycle of read latency, then pulses done while both operands are presented.
module operand_fetch_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] addr_A,
    input  logic [WIDTH-1:0] addr_B,
    input  logic [WIDTH-1:0] mem_data_in,
    output logic             mem_rd,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mux_ctrl,
    output logic [WIDTH-1:0] data_A,
    output logic [WIDTH-1:0] data_B,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_A   = 3'd1,
        S_WAIT_A = 3'd2,
        S_RD_B   = 3'd3,
        S_WAIT_B = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] addr_a_q;
    logic [WIDTH-1:0] addr_b_q;
    logic [WIDTH-1:0] data_a_q;
    logic [WIDTH-1:0] data_b_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic             mem_rd_q;
    logic             mux_ctrl_q;
    logic             busy_q;
    logic             done_q;

    // Outputs are loaded with the values of the state being entered, so every
    // output is a flop and mem_addr always tracks mux_ctrl over the latched addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            mux_ctrl_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_a_q   <= addr_A;
                        addr_b_q   <= addr_B;
                        mem_addr_q <= addr_A;
                        mem_rd_q   <= 1'b1;
                        mux_ctrl_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    state_q <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    data_a_q   <= mem_data_in;
                    mem_rd_q   <= 1'b1;
                    mux_ctrl_q <= 1'b1;
                    mem_addr_q <= addr_b_q;
                    state_q    <= S_RD_B;
                end
                S_RD_B: begin
                    state_q <= S_WAIT_B;
                end
                S_WAIT_B: begin
                    data_b_q   <= mem_data_in;
                    mux_ctrl_q <= 1'b0;
                    mem_addr_q <= addr_a_q;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    mux_ctrl_q <= 1'b0;
                    mem_addr_q <= addr_a_q;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign mux_ctrl = mux_ctrl_q;
    assign data_A   = data_a_q;
    assign data_B   = data_b_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
